pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline (FETCH..WRITEBACK): detects load-use and RAW hazards,

---
 rtl/pipeline_hazard_ctrl_if.sv | 47 ++++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the core's stage flops (master) and pipeline_hazard_ctrl (slave).
// Carries the decode/execute/memory/writeback hazard inputs and the stall/flush/forward controls.
interface pipeline_hazard_ctrl_if #(
  parameter int RF_ADDR_W = 5
) ();
  logic [RF_ADDR_W-1:0] id_rs1_addr;
  logic [RF_ADDR_W-1:0] id_rs2_addr;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic [RF_ADDR_W-1:0] ex_rd_addr;
  logic                 ex_rf_write_enable;
  logic                 ex_dm_read_enable;
  logic [RF_ADDR_W-1:0] mem_rd_addr;
  logic                 mem_rf_write_enable;
  logic [RF_ADDR_W-1:0] wb_rd_addr;
  logic                 wb_rf_write_enable;
  logic                 ex_redirect;
  logic                 dm_access;
  logic                 dm_ready;

  logic                 stall_fetch;
  logic                 stall_decode;
  logic                 bubble_execute;
  logic                 flush_decode;
  logic                 freeze_all;
  logic [1:0]           fwd_a_sel;
  logic [1:0]           fwd_b_sel;
  logic                 timeout_err;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_rf_write_enable, ex_dm_read_enable,
           mem_rd_addr, mem_rf_write_enable, wb_rd_addr, wb_rf_write_enable,
           ex_redirect, dm_access, dm_ready,
    input  stall_fetch, stall_decode, bubble_execute, flush_decode, freeze_all,
           fwd_a_sel, fwd_b_sel, timeout_err
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rd_addr, ex_rf_write_enable, ex_dm_read_enable,
           mem_rd_addr, mem_rf_write_enable, wb_rd_addr, wb_rf_write_enable,
           ex_redirect, dm_access, dm_ready,
    output stall_fetch, stall_decode, bubble_execute, flush_decode, freeze_all,
           fwd_a_sel, fwd_b_sel, timeout_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard sequencer: load-use stall, redirect flush, memory freeze/timeout, forwarding.
// Optional HAZARD_PERF_CNT_EN adds 32-bit cycle counters for stall, flush and memory-wait cycles.
module pipeline_hazard_ctrl #(
  parameter int RF_ADDR_W    = 5,
  parameter int MEM_TIMEOUT  = 15,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt,
  output logic [31:0]            perf_wait_cnt
`endif
);

  typedef enum logic [2:0] {RUN, LOAD_STALL, FLUSH, MEM_WAIT, ERROR} state_t;

  localparam logic [RF_ADDR_W-1:0] X0           = '0;
  localparam logic [7:0]           WAIT_LIMIT   = 8'(MEM_TIMEOUT);
  localparam logic [1:0]           FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state, eff_state, next_state, run_pick;
  logic [7:0] wait_cnt, wait_cnt_n;
  logic [1:0] flush_cnt, flush_cnt_n;
  logic       mem_wait_req, load_use, rs1_hit, rs2_hit;

  assign mem_wait_req = hz.dm_access & ~hz.dm_ready;
  assign rs1_hit      = hz.id_rs1_used & (hz.id_rs1_addr == hz.ex_rd_addr);
  assign rs2_hit      = hz.id_rs2_used & (hz.id_rs2_addr == hz.ex_rd_addr);
  // A load whose register write is squashed cannot feed the decode instruction.
  assign load_use     = hz.ex_dm_read_enable & hz.ex_rf_write_enable &
                        (hz.ex_rd_addr != X0) & (rs1_hit | rs2_hit);

  assign run_pick = mem_wait_req   ? MEM_WAIT   :
                    hz.ex_redirect ? FLUSH      :
                    load_use       ? LOAD_STALL : RUN;

  // NOTE: reset is sampled at the clock edge only; the output gating below covers the reset cycle itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_cnt_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // eff_state is what this cycle actually does: events seen in RUN act in the same cycle.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff_state   = RUN;
    next_state  = RUN;
    wait_cnt_n  = '0;
    flush_cnt_n = '0;

    case (state)
      FLUSH:    eff_state = mem_wait_req ? MEM_WAIT : FLUSH;
      MEM_WAIT: eff_state = hz.dm_ready ? run_pick : MEM_WAIT;
      ERROR:    eff_state = ERROR;
      default:  eff_state = run_pick;
    endcase

    case (eff_state)
      MEM_WAIT: begin
        wait_cnt_n = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        next_state = (wait_cnt_n >= WAIT_LIMIT) ? ERROR : MEM_WAIT;
      end
      FLUSH: begin
        // Counter holds the flush cycles still owed after this one.
        flush_cnt_n = hz.ex_redirect ? FLUSH_RELOAD : flush_cnt - 2'd1;
        next_state  = (flush_cnt_n == 2'd0) ? RUN : FLUSH;
      end
      ERROR:   next_state = ERROR;
      default: next_state = RUN;
    endcase
  end

  function automatic logic [1:0] fwd_sel(
    input logic [RF_ADDR_W-1:0] rs,
    input logic                 used,
    input logic [RF_ADDR_W-1:0] mem_rd,
    input logic                 mem_we,
    input logic [RF_ADDR_W-1:0] wb_rd,
    input logic                 wb_we
  );
    if (!used || rs == X0)          return 2'b00;
    if (mem_we && mem_rd == rs)     return 2'b01;
    if (wb_we && wb_rd == rs)       return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    hz.stall_fetch    = 1'b0;
    hz.stall_decode   = 1'b0;
    hz.bubble_execute = 1'b0;
    hz.flush_decode   = 1'b0;
    hz.freeze_all     = 1'b0;
    hz.timeout_err    = 1'b0;
    hz.fwd_a_sel      = 2'b00;
    hz.fwd_b_sel      = 2'b00;
    if (rst) begin
      case (eff_state)
        LOAD_STALL: begin
          hz.stall_fetch    = 1'b1;
          hz.stall_decode   = 1'b1;
          hz.bubble_execute = 1'b1;
        end
        FLUSH: begin
          hz.flush_decode   = 1'b1;
          hz.bubble_execute = 1'b1;
        end
        MEM_WAIT: begin
          hz.freeze_all   = 1'b1;
          hz.stall_fetch  = 1'b1;
          hz.stall_decode = 1'b1;
        end
        ERROR: begin
          hz.freeze_all  = 1'b1;
          hz.timeout_err = 1'b1;
        end
        default: ;
      endcase
      hz.fwd_a_sel = fwd_sel(hz.id_rs1_addr, hz.id_rs1_used, hz.mem_rd_addr,
                             hz.mem_rf_write_enable, hz.wb_rd_addr, hz.wb_rf_write_enable);
      hz.fwd_b_sel = fwd_sel(hz.id_rs2_addr, hz.id_rs2_used, hz.mem_rd_addr,
                             hz.mem_rf_write_enable, hz.wb_rd_addr, hz.wb_rf_write_enable);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (eff_state == LOAD_STALL) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (eff_state == FLUSH)      perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (eff_state == MEM_WAIT)   perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: cycle vectors with hand-derived expected controls.
// Expected values are queued when a vector is driven and compared mid-cycle at the falling edge.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.RF_ADDR_W(AW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

  pipeline_hazard_ctrl #(.RF_ADDR_W(AW), .MEM_TIMEOUT(15), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  // Control field order: stall_fetch, stall_decode, bubble_execute, flush_decode, freeze_all
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b11001;
  localparam logic [4:0] C_ERR   = 5'b00001;

  typedef struct {
    string       name;
    logic        r;
    logic [4:0]  rs1;  logic u1;
    logic [4:0]  rs2;  logic u2;
    logic [4:0]  ex_rd;  logic ex_we; logic ex_ld;
    logic [4:0]  mem_rd; logic mem_we;
    logic [4:0]  wb_rd;  logic wb_we;
    logic        redir; logic dacc; logic drdy;
    logic [9:0]  exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [9:0] e(input logic [4:0] c, input logic [1:0] fa,
                                   input logic [1:0] fb, input logic te);
    return {c, fa, fb, te};
  endfunction

  function automatic vec_t mk(input string n, input logic r,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] ex_rd, input logic ex_we, input logic ex_ld,
                              input logic [4:0] mem_rd, input logic mem_we,
                              input logic [4:0] wb_rd, input logic wb_we,
                              input logic redir, input logic dacc, input logic drdy,
                              input logic [9:0] exp);
    vec_t v;
    v.name = n;  v.r = r;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.ex_rd = ex_rd; v.ex_we = ex_we; v.ex_ld = ex_ld;
    v.mem_rd = mem_rd; v.mem_we = mem_we;
    v.wb_rd = wb_rd; v.wb_we = wb_we;
    v.redir = redir; v.dacc = dacc; v.drdy = drdy;
    v.exp = exp;
    return v;
  endfunction

  function automatic vec_t mk_ctl(input string n, input logic r, input logic redir,
                                  input logic dacc, input logic drdy, input logic [9:0] exp);
    return mk(n, r, 0,0, 0,0, 0,0,0, 0,0, 0,0, redir, dacc, drdy, exp);
  endfunction

  task automatic check_outputs();
    sb_t        s;
    logic [9:0] act;
    act = {hz.stall_fetch, hz.stall_decode, hz.bubble_execute, hz.flush_decode,
           hz.freeze_all, hz.fwd_a_sel, hz.fwd_b_sel, hz.timeout_err};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: no expected entry, got %b", act);
      return;
    end
    s = sb_q.pop_front();
    if (act !== s.exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (sf sd bx fd fz fa fb te)", s.name, act, s.exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t s;
    @(posedge clk);
    #1;
    rst                    = v.r;
    hz.id_rs1_addr         = v.rs1;
    hz.id_rs1_used         = v.u1;
    hz.id_rs2_addr         = v.rs2;
    hz.id_rs2_used         = v.u2;
    hz.ex_rd_addr          = v.ex_rd;
    hz.ex_rf_write_enable  = v.ex_we;
    hz.ex_dm_read_enable   = v.ex_ld;
    hz.mem_rd_addr         = v.mem_rd;
    hz.mem_rf_write_enable = v.mem_we;
    hz.wb_rd_addr          = v.wb_rd;
    hz.wb_rf_write_enable  = v.wb_we;
    hz.ex_redirect         = v.redir;
    hz.dm_access           = v.dacc;
    hz.dm_ready            = v.drdy;
    s.name = v.name;
    s.exp  = v.exp;
    sb_q.push_back(s);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    hz.id_rs1_addr = '0; hz.id_rs1_used = 1'b0; hz.id_rs2_addr = '0; hz.id_rs2_used = 1'b0;
    hz.ex_rd_addr = '0; hz.ex_rf_write_enable = 1'b0; hz.ex_dm_read_enable = 1'b0;
    hz.mem_rd_addr = '0; hz.mem_rf_write_enable = 1'b0;
    hz.wb_rd_addr = '0; hz.wb_rf_write_enable = 1'b0;
    hz.ex_redirect = 1'b0; hz.dm_access = 1'b0; hz.dm_ready = 1'b1;

    //                 name                 r  rs1 u1 rs2 u2 exrd we ld memrd we wbrd we  rd da dr  expected
    vecs.push_back(mk("rst_hold_hazards",  0, 5,1, 0,0, 5,1,1, 5,1, 0,0, 1,1,0, e(C_NONE ,0,0,0)));
    vecs.push_back(mk("rst_idle",          0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk("run_idle",          1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk("lu_rs1",            1, 5,1, 0,0, 5,1,1, 0,0, 0,0, 0,0,1, e(C_STALL,0,0,0)));
    vecs.push_back(mk("lu_after_wb_fwd",   1, 5,1, 0,0, 0,0,0, 0,0, 5,1, 0,0,1, e(C_NONE ,2,0,0)));
    vecs.push_back(mk("fwd_mem_wins",      1, 9,1, 7,1, 7,1,0, 7,1, 7,1, 0,0,1, e(C_NONE ,0,1,0)));
    vecs.push_back(mk("fwd_wb_only",       1, 4,1, 4,1, 0,0,0, 0,0, 4,1, 0,0,1, e(C_NONE ,2,2,0)));
    vecs.push_back(mk("fwd_x0",            1, 0,1, 0,1, 0,1,0, 0,1, 0,1, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk("fwd_mem_we_off",    1, 6,1, 0,0, 0,0,0, 6,0, 6,1, 0,0,1, e(C_NONE ,2,0,0)));
    vecs.push_back(mk("lu_rd_x0",          1, 0,1, 0,0, 0,1,1, 0,0, 0,0, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk("lu_rs2_unused",     1, 1,1, 8,0, 8,1,1, 0,0, 0,0, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk("lu_rs2",            1, 1,1, 8,1, 8,1,1, 0,0, 0,0, 0,0,1, e(C_STALL,0,0,0)));
    vecs.push_back(mk("redir_beats_lu",    1, 5,1, 0,0, 5,1,1, 0,0, 0,0, 1,0,1, e(C_FLUSH,0,0,0)));
    vecs.push_back(mk("flush_2nd_lu_ign",  1, 5,1, 0,0, 5,1,1, 0,0, 0,0, 0,0,1, e(C_FLUSH,0,0,0)));
    vecs.push_back(mk("flush_done",        1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk_ctl("redir_a",           1, 1,0,1, e(C_FLUSH,0,0,0)));
    vecs.push_back(mk_ctl("redir_restart",     1, 1,0,1, e(C_FLUSH,0,0,0)));
    vecs.push_back(mk_ctl("restart_tail",      1, 0,0,1, e(C_FLUSH,0,0,0)));
    vecs.push_back(mk_ctl("restart_done",      1, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk_ctl("mw1_beats_redir",   1, 1,1,0, e(C_FRZ  ,0,0,0)));
    vecs.push_back(mk_ctl("mw2_redir_pend",    1, 1,1,0, e(C_FRZ  ,0,0,0)));
    vecs.push_back(mk_ctl("mw3_redir_pend",    1, 1,1,0, e(C_FRZ  ,0,0,0)));
    vecs.push_back(mk_ctl("mw_exit_redir",     1, 1,1,1, e(C_FLUSH,0,0,0)));
    vecs.push_back(mk_ctl("mw_exit_tail",      1, 0,0,1, e(C_FLUSH,0,0,0)));
    vecs.push_back(mk_ctl("mw_after",          1, 0,0,1, e(C_NONE ,0,0,0)));
    vecs.push_back(mk("mw_beats_lu",       1, 5,1, 0,0, 5,1,1, 5,1, 0,0, 0,1,0, e(C_FRZ  ,1,0,0)));
    vecs.push_back(mk("mw_exit_lu",        1, 5,1, 0,0, 5,1,1, 5,1, 0,0, 0,1,1, e(C_STALL,1,0,0)));
    vecs.push_back(mk_ctl("mw_lu_done",        1, 0,0,1, e(C_NONE ,0,0,0)));

    foreach (vecs[i]) apply(vecs[i]);

    // Timeout: 15 consecutive not-ready cycles, the 15th one tipping into ERROR.
    for (int i = 0; i < 15; i++)
      apply(mk_ctl($sformatf("to_low_%0d", i + 1), 1, 0,1,0, e(C_FRZ,0,0,0)));
    apply(mk_ctl("err_entered",   1, 0,0,1, e(C_ERR,0,0,1)));
    apply(mk("err_hold_hazards", 1, 5,1, 0,0, 5,1,1, 0,0, 0,0, 1,1,0, e(C_ERR,0,0,1)));
    apply(mk_ctl("err_in_reset",  0, 0,0,1, e(C_NONE,0,0,0)));
    apply(mk_ctl("err_cleared",   1, 0,0,1, e(C_NONE,0,0,0)));

    // Reset mid MEM_WAIT must clear the wait counter: 14 more low cycles then stay below the limit.
    apply(mk_ctl("rmw_low_1",     1, 0,1,0, e(C_FRZ ,0,0,0)));
    apply(mk_ctl("rmw_low_2",     1, 0,1,0, e(C_FRZ ,0,0,0)));
    apply(mk_ctl("rmw_rst",       0, 0,1,0, e(C_NONE,0,0,0)));
    for (int i = 0; i < 14; i++)
      apply(mk_ctl($sformatf("rmw_relow_%0d", i + 1), 1, 0,1,0, e(C_FRZ,0,0,0)));
    apply(mk_ctl("rmw_ready",     1, 0,1,1, e(C_NONE,0,0,0)));
    apply(mk_ctl("rmw_idle",      1, 0,0,1, e(C_NONE,0,0,0)));

    // Reset mid FLUSH aborts the remaining flush cycle.
    apply(mk_ctl("rfl_redir",     1, 1,0,1, e(C_FLUSH,0,0,0)));
    apply(mk_ctl("rfl_rst",       0, 0,0,1, e(C_NONE ,0,0,0)));
    apply(mk_ctl("rfl_idle",      1, 0,0,1, e(C_NONE ,0,0,0)));

`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({perf_stall_cnt, perf_flush_cnt, perf_wait_cnt} !== 96'd0) begin
      n_bad++;
      $display("FAIL perf_after_reset: got %0d/%0d/%0d expected 0/0/0",
               perf_stall_cnt, perf_flush_cnt, perf_wait_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
